// File: rtl/clock_divider_prog.sv
// clock_divider_prog: runtime-programmable clock divider and CPU clock-enable
// generator with a debug single-step mode.
// Optional feature: define PERIOD_COUNT_EN to add a 32-bit period_count output
// that counts completed periods (ticks).
module clock_divider_prog #(
  parameter int unsigned      WIDTH        = 28,
  parameter logic [WIDTH-1:0] DEFAULT_DIV  = WIDTH'(50_000_000),
  parameter logic [WIDTH-1:0] DEFAULT_HIGH = WIDTH'(0)
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             mode,
  input  logic             step_req,
  input  logic [WIDTH-1:0] div_value,
  input  logic [WIDTH-1:0] high_value,
  input  logic             div_load,
  output logic             clock_out,
  output logic             tick,
  output logic             running
`ifdef PERIOD_COUNT_EN
  , output logic [31:0]    period_count
`endif
);

  // ST_INIT means "not yet decided": the first enabled edge picks RUN or
  // STEP_IDLE from the mode input sampled at that edge.
  typedef enum logic [1:0] {
    ST_INIT      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STEP_IDLE = 2'd2,
    ST_STEP_RUN  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           cur_state_s;
  state_t           next_state_s;
  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] div_q_r;
  logic [WIDTH-1:0] high_q_r;
  logic [WIDTH-1:0] pend_div_r;
  logic [WIDTH-1:0] pend_high_r;
  logic             pend_valid_r;
  logic             step_q_r;
  logic             clock_out_r;
  logic             tick_r;
  logic             running_r;
  logic [WIDTH-1:0] div_eff_s;
  logic [WIDTH-1:0] high_eff_s;
  logic             last_s;
  logic             step_rise_s;
  logic             counting_s;
  logic             wrap_s;
  logic             apply_s;

  assign clock_out = clock_out_r;
  assign tick      = tick_r;
  assign running   = running_r;

  // Effective divisor/high time after clamping, and end-of-period detect.
  // last_s uses >= so a corrupted count still terminates the period.
  always_comb begin
    div_eff_s = div_q_r;
    if (div_q_r < WIDTH'(2)) begin
      div_eff_s = WIDTH'(2);
    end else begin
      div_eff_s = div_q_r;
    end
    if ((high_q_r == {WIDTH{1'b0}}) || (high_q_r >= div_eff_s)) begin
      high_eff_s = div_eff_s >> 1;
    end else begin
      high_eff_s = high_q_r;
    end
    last_s = (cnt_r >= (div_eff_s - WIDTH'(1)));
  end

  // Resolve the undecided post-reset state and compute control strobes.
  always_comb begin
    cur_state_s = state_r;
    if (state_r == ST_INIT) begin
      cur_state_s = mode ? ST_STEP_IDLE : ST_RUN;
    end else begin
      cur_state_s = state_r;
    end
    step_rise_s = step_req & ~step_q_r;
    counting_s  = (cur_state_s == ST_RUN) || (cur_state_s == ST_STEP_RUN);
    wrap_s      = enable & counting_s & last_s;
    apply_s     = pend_valid_r & enable & (wrap_s | (cur_state_s == ST_STEP_IDLE));
  end

  // Next-state logic; mode changes only take effect at a wrap or from idle.
  always_comb begin
    next_state_s = cur_state_s;
    case (cur_state_s)
      ST_RUN, ST_STEP_RUN: begin
        if (last_s) begin
          next_state_s = mode ? ST_STEP_IDLE : ST_RUN;
        end else begin
          next_state_s = cur_state_s;
        end
      end
      ST_STEP_IDLE: begin
        if (!mode) begin
          next_state_s = ST_RUN;
        end else if (step_rise_s) begin
          next_state_s = ST_STEP_RUN;
        end else begin
          next_state_s = ST_STEP_IDLE;
        end
      end
      default: next_state_s = ST_STEP_IDLE;
    endcase
  end

  // Step request edge detector; runs every cycle regardless of enable.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      step_q_r <= 1'b0;
    end else begin
      step_q_r <= step_req;
    end
  end

  // Pending divisor/high-time capture; a new load wins over clearing.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      pend_div_r   <= DEFAULT_DIV;
      pend_high_r  <= DEFAULT_HIGH;
      pend_valid_r <= 1'b0;
    end else if (div_load) begin
      pend_div_r   <= div_value;
      pend_high_r  <= high_value;
      pend_valid_r <= 1'b1;
    end else if (apply_s) begin
      pend_valid_r <= 1'b0;
    end else begin
      pend_valid_r <= pend_valid_r;
    end
  end

  // Active divisor/high-time registers, updated only at period boundaries.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      div_q_r  <= DEFAULT_DIV;
      high_q_r <= DEFAULT_HIGH;
    end else if (apply_s) begin
      div_q_r  <= pend_div_r;
      high_q_r <= pend_high_r;
    end else begin
      div_q_r  <= div_q_r;
      high_q_r <= high_q_r;
    end
  end

  // Main FSM: counter, state and registered outputs from the pre-increment count.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_INIT;
      cnt_r       <= {WIDTH{1'b0}};
      clock_out_r <= 1'b0;
      tick_r      <= 1'b0;
      running_r   <= 1'b0;
    end else if (enable) begin
      state_r <= next_state_s;
      if (counting_s) begin
        clock_out_r <= (cnt_r < high_eff_s);
        tick_r      <= last_s;
        running_r   <= 1'b1;
        cnt_r       <= last_s ? {WIDTH{1'b0}} : (cnt_r + WIDTH'(1));
      end else begin
        clock_out_r <= 1'b0;
        tick_r      <= 1'b0;
        running_r   <= 1'b0;
        cnt_r       <= {WIDTH{1'b0}};
      end
    end else begin
      tick_r <= 1'b0;
    end
  end

`ifdef PERIOD_COUNT_EN
  logic [31:0] period_count_r;
  assign period_count = period_count_r;

  // Completed-period counter, stepped on the edge that raises tick.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      period_count_r <= 32'd0;
    end else if (wrap_s) begin
      period_count_r <= period_count_r + 32'd1;
    end else begin
      period_count_r <= period_count_r;
    end
  end
`endif

endmodule

// File: tb/tb_clock_divider_prog.sv
// Testbench for clock_divider_prog: directed scenarios followed by randomized
// stimulus, checked through an expected-output queue against a cycle model.
module tb_clock_divider_prog;

  localparam int DEF_DIV = 4;
  localparam int P_UNDECIDED = 0;
  localparam int P_FREE = 1;
  localparam int P_IDLE = 2;
  localparam int P_STEP = 3;

  logic        clock_in = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        mode = 1'b0;
  logic        step_req = 1'b0;
  logic [27:0] div_value = 28'd0;
  logic [27:0] high_value = 28'd0;
  logic        div_load = 1'b0;
  logic        clock_out;
  logic        tick;
  logic        running;
`ifdef PERIOD_COUNT_EN
  logic [31:0] period_count;
`endif

  clock_divider_prog #(
    .WIDTH(28),
    .DEFAULT_DIV(28'd4),
    .DEFAULT_HIGH(28'd0)
  ) dut (
    .clock_in(clock_in),
    .reset_n(reset_n),
    .enable(enable),
    .mode(mode),
    .step_req(step_req),
    .div_value(div_value),
    .high_value(high_value),
    .div_load(div_load),
    .clock_out(clock_out),
    .tick(tick),
    .running(running)
`ifdef PERIOD_COUNT_EN
    , .period_count(period_count)
`endif
  );

  always #5 clock_in = ~clock_in;

  // Expected {clock_out, tick, running} for each sampling point.
  logic [2:0] exp_q[$];
  event       sample_ev;
  int         vectors = 0;
  int         miscompares = 0;
  int         pushed = 0;

  // Reference model state: period-level view of the divider.
  int m_div, m_high, p_div, p_high, pos, phase;
  bit p_valid, prev_step, e_co, e_tk, e_rn;

  task automatic model_reset();
    m_div = DEF_DIV; m_high = 0; p_div = DEF_DIV; p_high = 0; p_valid = 1'b0;
    pos = 0; phase = P_UNDECIDED; prev_step = 1'b0;
    e_co = 1'b0; e_tk = 1'b0; e_rn = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs now being driven.
  task automatic model_cycle();
    bit rise, was_idle, wrapped;
    int de, he;
    rise = step_req && !prev_step;
    prev_step = step_req;
    de = (m_div < 2) ? 2 : m_div;
    he = (m_high == 0 || m_high >= de) ? de / 2 : m_high;
    wrapped = 1'b0;
    was_idle = 1'b0;
    if (enable) begin
      if (phase == P_UNDECIDED) phase = mode ? P_IDLE : P_FREE;
      if (phase == P_IDLE) begin
        was_idle = 1'b1;
        e_co = 1'b0; e_tk = 1'b0; e_rn = 1'b0;
        if (!mode) phase = P_FREE;
        else if (rise) phase = P_STEP;
      end else begin
        e_co = (pos < he);
        e_tk = (pos == de - 1);
        e_rn = 1'b1;
        if (pos == de - 1) begin
          pos = 0;
          wrapped = 1'b1;
          phase = mode ? P_IDLE : P_FREE;
        end else begin
          pos = pos + 1;
        end
      end
      if (p_valid && (wrapped || was_idle)) begin
        m_div = p_div; m_high = p_high; p_valid = 1'b0;
      end
    end else begin
      e_tk = 1'b0;
    end
    if (div_load) begin
      p_div = int'(div_value); p_high = int'(high_value); p_valid = 1'b1;
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the expected outputs.
  task automatic cyc(input bit en, input bit md, input bit st, input bit ld,
                     input int dv, input int hv);
    @(negedge clock_in);
    enable = en; mode = md; step_req = st; div_load = ld;
    div_value = 28'(dv); high_value = 28'(hv);
    if (!reset_n) model_reset();
    else model_cycle();
    exp_q.push_back({e_co, e_tk, e_rn});
    pushed++;
  endtask

  // Monitor: pop and compare on every rising edge or forced sample point.
  initial begin
    logic [2:0] exp;
    forever begin
      @(posedge clock_in or sample_ev);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        vectors++;
        if ({clock_out, tick, running} !== exp) begin
          miscompares++;
          $display("FAIL outputs vec %0d t=%0t: got clock_out/tick/running=%b required %b",
                   vectors, $time, {clock_out, tick, running}, exp);
        end
      end
    end
  end

  initial begin
    bit md, st;
    int guard;
    model_reset();
    // Reset held for a few cycles.
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    @(posedge clock_in); #2 reset_n = 1'b1;
    // Free-run at default divisor 4, 50 % duty.
    repeat (12) cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    // Load 5/1 mid-period; current period finishes at 4.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 5, 1);
    repeat (16) cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    // Clamping: divisor 1 and high 7 become 2 and 1.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1, 7);
    repeat (10) cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    // Back to 4 with two loads in a row: last one wins.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 9, 3);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4, 0);
    repeat (8) cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    // Single-step: enter idle at the next wrap, then two steps 20 cycles apart,
    // with an extra edge raised inside the first stepped period.
    repeat (6) cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    repeat (16) cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    repeat (8) cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    // Back to free-run, then freeze 3 cycles at count 2.
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    guard = 0;
    while (pos != 2 && guard < 20) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      guard++;
    end
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    repeat (6) cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    // Short reset pulse while clock_out is high.
    guard = 0;
    while (!e_co && guard < 20) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      guard++;
    end
    @(posedge clock_in);
    #2 reset_n = 1'b0;
    model_reset();
    exp_q.push_back(3'b000);
    pushed++;
    -> sample_ev;
    #2 reset_n = 1'b1;
    repeat (12) cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    // Randomized traffic.
    md = 1'b0;
    st = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) md = ~md;
      if ($urandom_range(0, 7) == 0) st = ~st;
      cyc($urandom_range(0, 9) != 0, md, st, $urandom_range(0, 19) == 0,
          int'($urandom_range(0, 9)), int'($urandom_range(0, 10)));
    end
    @(posedge clock_in);
    #3;
    vectors++;
    if (vectors != pushed + 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d samples with %0d left, required %0d with 0 left",
               vectors - 1, exp_q.size(), pushed);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
Parametrised, runtime-programmable clock divider and CPU clock-enable generator for the single-cycle CPU board top.
- Divides clock_in by a software- or switch-selectable divisor with programmable high time.
- Emits a one-cycle tick strobe per period.
- Supports a single-step mode so the CPU can be clocked one instruction per button press during debug.
- Sits between the board oscillator and the CPU clock/enable input.

Parameters:
WIDTH, 28, width of counter, divisor and high-time values
DEFAULT_DIV, 50000000, divisor loaded at reset (must be >= 2 and < 2**WIDTH)
DEFAULT_HIGH, 0, high time loaded at reset; 0 selects 50 % duty (DEFAULT_DIV >> 1)

Ports:
clock_in  input  1  board clock; all logic on its rising edge
reset_n  input  1  asynchronous, active-low reset
enable  input  1  1 = divider advances; 0 = freeze
mode  input  1  0 = free-run, 1 = single-step
step_req  input  1  step request (level, already debounced and synchronised); rising edge detected internally
div_value  input  WIDTH  new divisor
high_value  input  WIDTH  new high time; 0 = 50 % duty
div_load  input  1  one-cycle strobe: capture div_value/high_value into pending registers
clock_out  output  1  divided clock, registered
tick  output  1  one-cycle strobe on the last cycle of each period, registered
running  output  1  1 while a period is in progress (RUN or STEP_RUN)

Behaviour:
- Reset (reset_n=0, asynchronous):
  - cnt=0; clock_out=0; tick=0; running=0.
  - div_q=DEFAULT_DIV; high_q=DEFAULT_HIGH; pending registers = defaults; pend_valid=0; step edge register=0.
  - State is RUN if mode=1'b0 is sampled at release, otherwise STEP_IDLE (state decided on first enabled edge).
- Effective values:
  - div_eff = max(div_q, 2).
  - high_eff = div_eff >> 1 when high_q=0 or high_q >= div_eff; otherwise high_eff = high_q.
  - All comparisons are unsigned, WIDTH bits.
- States:
  - RUN: cnt increments each enabled cycle and wraps to 0 when cnt == div_eff-1.
  - STEP_IDLE: cnt held at 0; clock_out=0; running=0.
  - STEP_RUN: runs exactly one period, then goes to STEP_IDLE.
- Transitions:
  - RUN -> STEP_IDLE at a wrap when mode=1.
  - STEP_IDLE -> RUN when mode=0.
  - STEP_IDLE -> STEP_RUN on a step_req rising edge while mode=1.
  - STEP_RUN -> STEP_IDLE at wrap when mode=1; STEP_RUN -> RUN at wrap when mode=0.
- Mode changes never truncate a period; they take effect only at a wrap or from STEP_IDLE.
- Output timing on each enabled edge in RUN or STEP_RUN, using the pre-increment cnt:
  - clock_out <= (cnt < high_eff).
  - tick <= (cnt == div_eff-1).
  - Output lags the counter by one cycle. Period = div_eff cycles; high time = high_eff cycles.
- Reprogramming:
  - div_load sets pend_valid and captures both values.
  - Pending values move into div_q/high_q at the next wrap, or immediately in STEP_IDLE, and pend_valid clears.
  - A second div_load before application overwrites the pending values; the last one wins.
  - div_load coincident with a wrap: the new values are captured as pending and applied at the following wrap. The old pending values apply at this wrap if pend_valid was already set.
- Step requests:
  - step_req edges during STEP_RUN or RUN are ignored and not queued.
  - The edge detector updates every cycle regardless of enable.
- enable=0:
  - cnt, state and clock_out hold; tick forced 0 on the next edge.
  - Pending loads are still captured but not applied until enabled.
- Reset mid-period returns all outputs to reset values immediately, with no partial-period glitch beyond reset assertion.

Optional Feature:
PERIOD_COUNT_EN
- Defined: adds output period_count (32 bits), reset to 0. It increments on every cycle where tick is asserted and wraps at 2**32-1 -> 0. It gives the debugger an executed-cycle count.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- DEFAULT_DIV=4, DEFAULT_HIGH=0, mode=0, enable=1 after reset -> clock_out pattern 1,1,0,0 repeating from the 1st edge; tick high every 4th cycle; running=1.
- div_value=5, high_value=1, div_load mid-period -> current period completes at 4 cycles; subsequent periods are 5 cycles with clock_out high for 1 cycle.
- div_value=1, high_value=7 -> clamped to div_eff=2, high_eff=1; clock_out toggles 1,0.
- mode=1, then two step_req rising edges 20 cycles apart -> exactly two 4-cycle periods, two ticks; clock_out=0 and running=0 between them. An extra edge raised during STEP_RUN produces no extra period.
- enable=0 for 3 cycles at cnt=2 -> clock_out holds, tick=0; the period resumes and finishes 2 cycles after re-enable.
- reset_n pulsed low for less than one cycle mid-high-phase -> clock_out, tick and running are 0 immediately. With PERIOD_COUNT_EN defined, period_count=0 and it counts 3 after 12 enabled cycles at div 4.
